// File: rtl/ofdm_pkg.sv
// Shared types and defaults for the OFDM demodulation controller.
// Holds the controller state enum, default frame/bin sizing constants and
// the bin payload struct (real/imag components at the default width).
package ofdm_pkg;

    localparam int unsigned N_SC_DEFAULT = 8;
    localparam int unsigned W_DEFAULT    = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // FFT bin payload: re = real component, im = imaginary component
    typedef struct packed {
        logic signed [W_DEFAULT-1:0] re;
        logic signed [W_DEFAULT-1:0] im;
    } bin_t;

endpackage

// File: rtl/ofdm_demod_ctrl_qpsk_slicer.sv
// qpsk_slicer: combinational hard-decision QPSK slicer.
// Ports:
//   re, im  in   signed bin components
//   x       out  sign(im)
//   y       out  sign(re) ^ sign(im)
//   zero    out  either component exactly zero (only built with
//                OFDM_DEMOD_ERASE_EN, otherwise tied 0)
// Optional feature macro: OFDM_DEMOD_ERASE_EN
module qpsk_slicer #(
    parameter int unsigned W = 24
) (
    input  logic signed [W-1:0] re,
    input  logic signed [W-1:0] im,
    output logic                x,
    output logic                y,
    output logic                zero
);

    logic re_neg;
    logic im_neg;

    // Zero counts as non-negative, so a plain signed compare is the sign
    assign re_neg = (re < 0);
    assign im_neg = (im < 0);

    assign x = im_neg;
    assign y = re_neg ^ im_neg;

`ifdef OFDM_DEMOD_ERASE_EN
    assign zero = (re == '0) || (im == '0);
`else
    assign zero = 1'b0;
`endif

endmodule

// File: rtl/ofdm_demod_ctrl.sv
// ofdm_demod_ctrl: buffers one OFDM frame of FFT bins, then drains it as
// QPSK bit-pair decisions. Fill and drain never overlap.
// Ports:
//   clk, reset                  clock, async active-high reset
//   bin_valid/bin_ready         input bin handshake
//   bin_real, bin_imag          signed bin components (W bits)
//   bin_last                    final bin of the frame
//   out_valid/out_ready         decision handshake
//   out_x, out_y                demodulated bit pair
//   out_sof, out_eof            first/last decision of the frame
//   out_erase                   unreliable decision (OFDM_DEMOD_ERASE_EN)
//   frame_err                   one-cycle pulse on a malformed frame
// Optional feature macro: OFDM_DEMOD_ERASE_EN (zero-component erasure flag)
module ofdm_demod_ctrl
    import ofdm_pkg::*;
#(
    parameter int unsigned N_SC = N_SC_DEFAULT,
    parameter int unsigned W    = W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bin_valid,
    output logic                bin_ready,
    input  logic signed [W-1:0] bin_real,
    input  logic signed [W-1:0] bin_imag,
    input  logic                bin_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_x,
    output logic                out_y,
    output logic                out_sof,
    output logic                out_eof,
    output logic                out_erase,
    output logic                frame_err
);

    localparam int unsigned     IDX_W    = (N_SC > 1) ? $clog2(N_SC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SC - 1);

    // Same layout as ofdm_pkg::bin_t, sized by this instance's W
    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } bin_w_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] wr_idx, wr_idx_d;
    logic [IDX_W-1:0] rd_idx, rd_idx_d;
    logic             frame_err_d;
    logic             draining;
    logic             bin_xfer;
    logic             out_xfer;

    bin_w_t           buffer [N_SC];
    bin_w_t           rd_bin;
    logic             sl_x, sl_y, sl_zero;

    assign draining  = (state == S_DRAIN);
    // Held low for the whole reset so no bin can slip in during reset
    assign bin_ready = !draining && !reset;
    assign bin_xfer  = bin_valid && bin_ready;
    assign out_xfer  = draining && out_ready;

    // State and index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            wr_idx    <= wr_idx_d;
            rd_idx    <= rd_idx_d;
            frame_err <= frame_err_d;
        end
    end

    // Next-state: frame framing check during fill, handshake-paced drain
    always_comb begin
        state_d     = state;
        wr_idx_d    = wr_idx;
        rd_idx_d    = rd_idx;
        frame_err_d = 1'b0;
        case (state)
            S_IDLE, S_FILL: begin
                if (bin_xfer) begin
                    if (wr_idx == LAST_IDX) begin
                        wr_idx_d = '0;
                        if (bin_last) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d     = S_IDLE;
                            frame_err_d = 1'b1;
                        end
                    end else if (bin_last) begin
                        wr_idx_d    = '0;
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx + IDX_W'(1);
                        state_d  = S_FILL;
                    end
                end
            end
            S_DRAIN: begin
                if (out_xfer) begin
                    if (rd_idx == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        rd_idx_d = rd_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                wr_idx_d = '0;
                rd_idx_d = '0;
            end
        endcase
    end

    // Bin storage; contents are don't-care across reset
    always_ff @(posedge clk) begin
        if (bin_xfer) begin
            buffer[wr_idx] <= '{re: bin_real, im: bin_imag};
        end
    end

    assign rd_bin = buffer[rd_idx];

    qpsk_slicer #(
        .W (W)
    ) u_slicer (
        .re   (rd_bin.re),
        .im   (rd_bin.im),
        .x    (sl_x),
        .y    (sl_y),
        .zero (sl_zero)
    );

    // Decision outputs are forced to 0 outside DRAIN
    assign out_valid = draining;
    assign out_x     = draining && sl_x;
    assign out_y     = draining && sl_y;
    assign out_sof   = draining && (rd_idx == '0);
    assign out_eof   = draining && (rd_idx == LAST_IDX);
    assign out_erase = draining && sl_zero;

endmodule

// File: tb/tb_ofdm_demod_ctrl.sv
// Self-checking bench for ofdm_demod_ctrl: directed frames plus randomized
// frames, checked against a quadrant-table reference model.
// Honours OFDM_DEMOD_ERASE_EN for the expected erase flag.
module tb_ofdm_demod_ctrl;

    localparam int unsigned N = 8;
    localparam int unsigned W = 24;

    logic                clk;
    logic                reset;
    logic                bin_valid;
    logic                bin_ready;
    logic signed [W-1:0] bin_real;
    logic signed [W-1:0] bin_imag;
    logic                bin_last;
    logic                out_valid;
    logic                out_ready;
    logic                out_x;
    logic                out_y;
    logic                out_sof;
    logic                out_eof;
    logic                out_erase;
    logic                frame_err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic signed [W-1:0] fr_re [N];
    logic signed [W-1:0] fr_im [N];

    ofdm_demod_ctrl #(.N_SC(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .bin_real  (bin_real),
        .bin_imag  (bin_imag),
        .bin_last  (bin_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_erase (out_erase),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Constellation table: (+,+)->00 (-,+)->01 (-,-)->10 (+,-)->11
    function automatic logic [1:0] ref_pair(input logic signed [W-1:0] re,
                                            input logic signed [W-1:0] im);
        if (re >= 0 && im >= 0) return 2'b00;
        else if (re < 0 && im >= 0) return 2'b01;
        else if (re < 0) return 2'b10;
        else return 2'b11;
    endfunction

    function automatic logic ref_erase(input logic signed [W-1:0] re,
                                       input logic signed [W-1:0] im);
`ifdef OFDM_DEMOD_ERASE_EN
        return (re == 0) || (im == 0);
`else
        return 1'b0 && (re == im);
`endif
    endfunction

    function automatic logic signed [W-1:0] rnd_comp();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return W'(int'($urandom_range(0, 6)) - 3);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic load_directed();
        fr_re[0] =  5; fr_im[0] =  5;
        fr_re[1] = -5; fr_im[1] =  5;
        fr_re[2] = -5; fr_im[2] = -5;
        fr_re[3] =  5; fr_im[3] = -5;
        fr_re[4] =  0; fr_im[4] =  0;
        fr_re[5] =  0; fr_im[5] = -1;
        fr_re[6] = -1; fr_im[6] =  0;
        fr_re[7] =  7; fr_im[7] =  7;
    endtask

    task automatic load_random();
        for (int i = 0; i < int'(N); i++) begin
            fr_re[i] = rnd_comp();
            fr_im[i] = rnd_comp();
        end
    endtask

    // Phase on entry/exit: 1 time unit after a rising edge
    task automatic send_frame(input int n, input int last_pos, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bin_valid = 1'b0;
                @(posedge clk); #1;
            end
            bin_valid = 1'b1;
            bin_real  = fr_re[i];
            bin_imag  = fr_im[i];
            bin_last  = (i == last_pos);
            @(negedge clk);
            check("fill_bin_ready", 32'(bin_ready), 32'd1);
            check("fill_out_valid", 32'(out_valid), 32'd0);
            check("fill_frame_err", 32'(frame_err), 32'd0);
            check("fill_out_x",     32'(out_x),     32'd0);
            @(posedge clk); #1;
        end
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    task automatic expect_frame_err();
        @(negedge clk);
        check("err_pulse",      32'(frame_err), 32'd1);
        check("err_out_valid",  32'(out_valid), 32'd0);
        check("err_bin_ready",  32'(bin_ready), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_pulse_end",  32'(frame_err), 32'd0);
        check("err_no_valid",   32'(out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    // mode: 0 always ready, 1 toggling 1010..., 2 random
    task automatic drain(input int mode, input bit hold_valid, input int stop_after);
        int k   = 0;
        int cyc = 0;
        logic acc;
        while (k < stop_after && cyc < 4 * int'(N) + 20) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (hold_valid) begin
                bin_valid = 1'b1;
                bin_real  = rnd_comp();
                bin_imag  = rnd_comp();
                bin_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check("drain_valid",     32'(out_valid), 32'd1);
            check("drain_pair",      32'({out_x, out_y}), 32'(ref_pair(fr_re[k], fr_im[k])));
            check("drain_sof",       32'(out_sof), 32'(k == 0));
            check("drain_eof",       32'(out_eof), 32'(k == int'(N) - 1));
            check("drain_erase",     32'(out_erase), 32'(ref_erase(fr_re[k], fr_im[k])));
            check("drain_bin_ready", 32'(bin_ready), 32'd0);
            check("drain_frame_err", 32'(frame_err), 32'd0);
            acc = out_ready;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        if (k < stop_after) check("drain_timeout", 32'(k), 32'(stop_after));
        out_ready = 1'b0;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        if (stop_after == int'(N)) begin
            @(negedge clk);
            check("post_valid",     32'(out_valid), 32'd0);
            check("post_bin_ready", 32'(bin_ready), 32'd1);
            check("post_outs",      32'({out_x, out_y, out_sof, out_eof, out_erase}), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        bin_valid = 1'b0;
        bin_real  = '0;
        bin_imag  = '0;
        bin_last  = 1'b0;
        out_ready = 1'b0;

        #2;
        check("rst_bin_ready", 32'(bin_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_outs",      32'({out_x, out_y, out_sof, out_eof, out_erase}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rel_bin_ready", 32'(bin_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Directed frame, always ready
        load_directed();
        send_frame(N, N - 1, 1'b0);
        drain(0, 1'b0, N);

        // Same frame, stalling every other cycle
        send_frame(N, N - 1, 1'b0);
        drain(1, 1'b0, N);

        // bin_last on the 5th bin
        load_random();
        send_frame(5, 4, 1'b0);
        expect_frame_err();
        load_directed();
        send_frame(N, N - 1, 1'b1);
        drain(0, 1'b0, N);

        // Missing bin_last on the final bin
        load_random();
        send_frame(N, -1, 1'b0);
        expect_frame_err();

        // bin_valid held high throughout drain, then a normal frame
        load_random();
        send_frame(N, N - 1, 1'b0);
        drain(2, 1'b1, N);
        load_random();
        send_frame(N, N - 1, 1'b0);
        drain(0, 1'b0, N);

        // Zero-component bin for the erase flag
        load_random();
        fr_re[0] = 0;
        fr_im[0] = -3;
        send_frame(N, N - 1, 1'b0);
        drain(0, 1'b0, N);

        // Reset after the 3rd accepted decision
        load_random();
        send_frame(N, N - 1, 1'b0);
        drain(0, 1'b0, 3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid",     32'(out_valid), 32'd0);
        check("mid_rst_outs",      32'({out_x, out_y, out_sof, out_eof, out_erase}), 32'd0);
        check("mid_rst_bin_ready", 32'(bin_ready), 32'd0);
        check("mid_rst_frame_err", 32'(frame_err), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rel_bin_ready", 32'(bin_ready), 32'd1);
        check("mid_rel_valid",     32'(out_valid), 32'd0);
        check("mid_rel_frame_err", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        load_random();
        send_frame(N, N - 1, 1'b0);
        drain(0, 1'b0, N);

        // Randomized frames with gaps and random backpressure
        for (int f = 0; f < 6; f++) begin
            load_random();
            send_frame(N, N - 1, 1'b1);
            drain(2, 1'($urandom_range(0, 1)), N);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ofdm_demod_ctrl.md
OFDM_DEMOD_CTRL -- requirements
Module: ofdm_demod_ctrl

Interface
REQ-001 Parameter N_SC, default 8, number of subcarriers per OFDM frame; legal values are powers of two from 2 to 64.
REQ-002 Parameter W, default 24, signed width of each bin component.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 bin_valid  input  1  FFT bin on bin_real/bin_imag is valid.
REQ-006 bin_ready  output  1  controller accepts a bin this cycle.
REQ-007 bin_real, bin_imag  input  W each  signed FFT bin components.
REQ-008 bin_last  input  1  marks the final bin of a frame.
REQ-009 out_valid  output  1  out_x/out_y hold a valid QPSK decision.
REQ-010 out_ready  input  1  downstream accepts a decision.
REQ-011 out_x, out_y  output  1 each  demodulated bit pair.
REQ-012 out_sof, out_eof  output  1 each  first/last decision of a frame, qualified by out_valid.
REQ-013 out_erase  output  1  decision is unreliable (see Configuration).
REQ-014 frame_err  output  1  one-cycle pulse on a malformed input frame.

Function
REQ-015 The FSM SHALL have states IDLE, FILL and DRAIN; reset enters IDLE.
REQ-016 bin_ready SHALL be 1 in IDLE and FILL and 0 in DRAIN; a bin transfers on bin_valid && bin_ready.
REQ-017 Accepted bins SHALL be written to buffer[wr_idx], with wr_idx counting 0..N_SC-1; the first transfer moves IDLE->FILL.
REQ-018 If the transfer at wr_idx==N_SC-1 has bin_last=1, the FSM SHALL go to DRAIN at the next edge and reset wr_idx to 0.
REQ-019 If bin_last=1 at wr_idx<N_SC-1, or bin_last=0 at wr_idx==N_SC-1, the frame SHALL be discarded, frame_err SHALL pulse for 1 cycle, the FSM SHALL return to IDLE, and wr_idx SHALL clear.
REQ-020 In DRAIN, out_valid SHALL be 1 and the outputs SHALL present the decision for buffer[rd_idx]; rd_idx advances on out_valid && out_ready.
REQ-021 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-022 out_sof SHALL be 1 when rd_idx==0; out_eof SHALL be 1 when rd_idx==N_SC-1.
REQ-023 Acceptance of rd_idx==N_SC-1 SHALL move DRAIN->IDLE and clear rd_idx; bin_ready SHALL be 1 in the next cycle.
REQ-024 Latency: the first out_valid SHALL occur 1 cycle after the last bin transfer.
REQ-025 Minimum frame period SHALL be 2*N_SC cycles; there is no fill/drain overlap.
REQ-026 Slicer mapping: out_x = sign(imag); out_y = sign(real) XOR sign(imag); sign(v)=1 iff v<0; zero counts as non-negative.
REQ-027 The resulting constellation SHALL be: (+,+)->00, (-,+)->01, (-,-)->10, (+,-)->11.
REQ-028 Outside DRAIN, out_x, out_y, out_sof, out_eof and out_erase SHALL be 0.

Reset
REQ-029 Asserting reset SHALL, without waiting for a clock edge, force state=IDLE, wr_idx=0, rd_idx=0, and bin_ready=0 for the duration of reset.
REQ-030 While reset is asserted, out_valid=0, frame_err=0 and all data outputs=0; buffer contents are don't-care.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the frame silently, with no frame_err.
REQ-032 After reset release, bin_ready SHALL be 1 in the first cycle.

Configuration
REQ-033 With macro OFDM_DEMOD_ERASE_EN defined, out_erase SHALL be 1 when out_valid=1 and either component of buffer[rd_idx] is exactly 0.
REQ-034 Without OFDM_DEMOD_ERASE_EN, out_erase SHALL be tied to 0 and no zero-detect logic is built.
REQ-035 The ports SHALL be identical in both builds.

Structure
REQ-036 Package ofdm_pkg SHALL hold the FSM state enum, the default N_SC and W constants, and the bin struct {real, imag}.
REQ-037 Sub-module qpsk_slicer (combinational: real/imag in -> x, y, zero flag) SHALL implement REQ-026 and REQ-033.
REQ-038 Sub-module qpsk_slicer SHALL be instantiated once on the buffer read port.

Verification
REQ-039 Frame bins (+5,+5),(-5,+5),(-5,-5),(+5,-5),(0,0),(0,-1),(-1,0),(7,7) with out_ready=1 -> pairs 00,01,10,11,00,11,01,00; out_sof on 1st, out_eof on 8th.
REQ-040 Same frame with out_ready toggling 1010... -> identical pair sequence, outputs stable during stalls, no drops.
REQ-041 bin_last at the 5th bin -> frame_err pulse, no out_valid; next well-formed frame decodes correctly.
REQ-042 bin_valid held high throughout DRAIN -> bin_ready=0 and no bins accepted until the cycle after the out_eof handshake.
REQ-043 Reset asserted after the 3rd decision is accepted -> outputs 0 immediately, then IDLE with bin_ready=1; no frame_err.
REQ-044 With OFDM_DEMOD_ERASE_EN, bin (0,-3) -> pair 11 with out_erase=1; without the macro -> out_erase=0.
